// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Bytes are queued through i_push/i_din. A small FSM (IDLE/START/WAIT) pops
// the head byte, raises a one-cycle o_tx_start, and then waits for i_tx_done.
// All outputs are registered. rst is asynchronous and active-low.
// Optional build macro UART_TX_FIFO_OVF_EN adds a sticky o_overflow flag
// and its clear input i_ovf_clr.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [7:0]    i_din,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_tx_start,
  output logic [7:0]    o_tx_data,
  input  logic          i_tx_busy,
  input  logic          i_tx_done
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic          o_overflow,
  input  logic          i_ovf_clr
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic [AW:0]   count_next;
  logic          push_ok;
  logic          pop;

  // Push/pop qualification and next-state logic. Full and empty come from
  // registered state, so a push into an empty FIFO is never popped in the
  // same cycle, and a push into a full FIFO is dropped even if a pop happens.
  always_comb begin
    push_ok    = i_push && !o_full;
    pop        = (state_reg == IDLE) && !o_empty && !i_tx_busy;
    count_next = o_count;
    state_next = state_reg;
    case ({push_ok, pop})
      2'b10:   count_next = o_count + 1'b1;
      2'b01:   count_next = o_count - 1'b1;
      default: count_next = o_count;
    endcase
    case (state_reg)
      IDLE:    if (pop) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (i_tx_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Storage array write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= i_din;
    end
  end

  // Pointers, count, status flags and the transmitter handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      o_count    <= '0;
      o_empty    <= 1'b1;
      o_full     <= 1'b0;
      state_reg  <= IDLE;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        o_tx_data  <= mem[rd_ptr_reg];
      end
      o_count    <= count_next;
      o_empty    <= (count_next == '0);
      o_full     <= (count_next == FULL_CNT);
      state_reg  <= state_next;
      o_tx_start <= (state_next == START);
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // Sticky overflow flag; a new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_overflow <= 1'b0;
    end else if (i_push && o_full) begin
      o_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      o_overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle away from the active
// edge. UART frames are modelled as a scaled busy window followed by a
// one-cycle done pulse.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       i_push;
  logic [7:0] i_din;
  logic       o_full;
  logic       o_empty;
  logic [3:0] o_count;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  logic       i_tx_done;
`ifdef UART_TX_FIFO_OVF_EN
  logic       o_overflow;
  logic       i_ovf_clr;
`endif

  int vectors = 0;
  int miscompares = 0;

  uart_tx_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_push     (i_push),
    .i_din      (i_din),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy),
    .i_tx_done  (i_tx_done)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .o_overflow (o_overflow),
    .i_ovf_clr  (i_ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Wait (bounded) for a start pulse, check its byte, then play one frame.
  task automatic serve_byte(input logic [7:0] exp);
    int   waited = 0;
    logic bad = 1'b0;
    while (o_tx_start !== 1'b1 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    chk("start_seen", {31'd0, o_tx_start}, 32'd1);
    chk("tx_data", {24'd0, o_tx_data}, {24'd0, exp});
    i_tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_tx_start !== 1'b0) bad = 1'b1;
    end
    chk("no_start_while_busy", {31'd0, bad}, 32'd0);
    i_tx_busy = 1'b0;
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  initial begin
    logic quiet;
    rst = 1'b0; i_push = 1'b0; i_din = 8'h00; i_tx_busy = 1'b0; i_tx_done = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    i_ovf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_count", {28'd0, o_count}, 32'd0);
    chk("rst_empty", {31'd0, o_empty}, 32'd1);
    chk("rst_full", {31'd0, o_full}, 32'd0);
    chk("rst_start", {31'd0, o_tx_start}, 32'd0);
    chk("rst_data", {24'd0, o_tx_data}, 32'h00);
    rst = 1'b1;
    @(negedge clk);

    // Single byte: start pulse in the second cycle after the push edge
    i_push = 1'b1; i_din = 8'h30;
    @(negedge clk);
    i_push = 1'b0;
    chk("one_cnt", {28'd0, o_count}, 32'd1);
    chk("one_empty", {31'd0, o_empty}, 32'd0);
    chk("one_nostart_yet", {31'd0, o_tx_start}, 32'd0);
    @(negedge clk);
    chk("one_start", {31'd0, o_tx_start}, 32'd1);
    chk("one_data", {24'd0, o_tx_data}, 32'h30);
    chk("one_empty_after", {31'd0, o_empty}, 32'd1);
    @(negedge clk);
    chk("one_pulse_end", {31'd0, o_tx_start}, 32'd0);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;

    // Fill while busy, ninth push dropped
    i_tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_push = 1'b1; i_din = 8'h41 + 8'(i);
      @(negedge clk);
    end
    i_din = 8'h49;
    @(negedge clk);
    i_push = 1'b0;
    chk("fill_full", {31'd0, o_full}, 32'd1);
    chk("fill_count", {28'd0, o_count}, 32'd8);
    chk("fill_nostart_busy", {31'd0, o_tx_start}, 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_set", {31'd0, o_overflow}, 32'd1);
    i_ovf_clr = 1'b1;
    @(negedge clk);
    i_ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, o_overflow}, 32'd0);
`endif

    // Push while full in the same cycle as a pop: push dropped, 8 -> 7
    i_tx_busy = 1'b0; i_push = 1'b1; i_din = 8'h4A;
    @(negedge clk);
    i_push = 1'b0;
    chk("fullpop_count", {28'd0, o_count}, 32'd7);
    chk("fullpop_full", {31'd0, o_full}, 32'd0);

    // Drain in order, one frame per byte
    for (int i = 0; i < 8; i++) serve_byte(8'h41 + 8'(i));
    chk("drain_empty", {31'd0, o_empty}, 32'd1);

    // Done while idle is ignored
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    @(negedge clk);
    chk("idle_done_nostart", {31'd0, o_tx_start}, 32'd0);

    // Wrap: queue 3, then 6 simultaneous push/pop, then drain
    i_tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_push = 1'b1; i_din = 8'h50 + 8'(i);
      @(negedge clk);
    end
    i_push = 1'b0;
    i_tx_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_push = 1'b1; i_din = 8'h53 + 8'(k);
      @(negedge clk);
      i_push = 1'b0;
      chk("pushpop_count", {28'd0, o_count}, 32'd3);
      serve_byte(8'h50 + 8'(k));
    end
    for (int k = 0; k < 3; k++) serve_byte(8'h56 + 8'(k));
    chk("wrap_empty", {31'd0, o_empty}, 32'd1);

    // Reset during WAIT with 4 bytes queued
    for (int i = 0; i < 5; i++) begin
      i_push = 1'b1; i_din = 8'h60 + 8'(i);
      @(negedge clk);
    end
    i_push = 1'b0;
    i_tx_busy = 1'b1;
    chk("pre_rst_count", {28'd0, o_count}, 32'd4);
    chk("pre_rst_data", {24'd0, o_tx_data}, 32'h60);
    rst = 1'b0;
    #1;
    chk("async_count", {28'd0, o_count}, 32'd0);
    chk("async_empty", {31'd0, o_empty}, 32'd1);
    chk("async_start", {31'd0, o_tx_start}, 32'd0);
    chk("async_data", {24'd0, o_tx_data}, 32'h00);
    @(negedge clk);
    rst = 1'b1; i_tx_busy = 1'b0;
    quiet = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_tx_start !== 1'b0) quiet = 1'b1;
    end
    chk("post_rst_nostart", {31'd0, quiet}, 32'd0);
    chk("post_rst_empty", {31'd0, o_empty}, 32'd1);
    i_push = 1'b1; i_din = 8'h70;
    @(negedge clk);
    i_push = 1'b0;
    serve_byte(8'h70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
